// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 16-channel round-robin mux and its matching 1-to-16 demux.
package mux_demux_pkg;

  localparam int N_CH   = 16;
  localparam int SEL_W  = 4;
  localparam int DATA_W = 1;

  // Channel index carried alongside every beat so the demux can route it back out
  typedef logic [SEL_W-1:0] ch_sel_t;

  // Output register occupancy
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mux_16to1_rr_arbiter_if.sv
// Bundle of the 16 input handshakes and the single output stream of the arbiter.
interface mux_16to1_rr_arbiter_if;

  logic [mux_demux_pkg::N_CH-1:0]                       in_valid;
  logic [mux_demux_pkg::N_CH*mux_demux_pkg::DATA_W-1:0] in_data;
  logic [mux_demux_pkg::N_CH-1:0]                       in_ready;
  logic                                                 out_valid;
  logic [mux_demux_pkg::DATA_W-1:0]                     out_data;
  mux_demux_pkg::ch_sel_t                               out_sel;
  logic                                                 out_ready;

  // Environment side: drives the sources and the downstream ready
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Arbiter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_pick16.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, find the lowest set bit,
// then rotate the found offset back into an absolute channel index.
module rr_pick16
  import mux_demux_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  ch_sel_t         ptr,
  output ch_sel_t         gnt_idx,
  output logic            gnt_any
);

  logic [N_CH-1:0] rot;
  ch_sel_t         off;

  // Rotate so that channel ptr lands on bit 0 and higher bits follow in round-robin order
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_CH; i++) begin
      rot[i] = req[ptr + SEL_W'(i)];
    end
  end

  // Lowest set bit of the rotated vector is the first requester at or after ptr
  always_comb begin
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  assign gnt_idx = ptr + off;
  assign gnt_any = |req;

endmodule

// File: rtl/mux_16to1_rr_arbiter.sv
// 16-to-1 round-robin stream mux with a single registered output stage.
// Each output beat is tagged with its source channel on out_sel.
module mux_16to1_rr_arbiter
  import mux_demux_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  mux_16to1_rr_arbiter_if.slave         bus
);

  out_state_t        state_q;
  logic [DATA_W-1:0] data_q;
  ch_sel_t           sel_q;
  ch_sel_t           ptr_q;
  ch_sel_t           ptr_d;

  ch_sel_t           gnt_idx;
  logic              gnt_any;
  logic              load_en;
  logic              take;
  logic [DATA_W-1:0] sel_data;

  rr_pick16 u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The output register can accept a new beat when empty or when its beat leaves this cycle
  assign load_en = (state_q == EMPTY) || bus.out_ready;
  assign take    = rst_n && load_en && gnt_any;
  assign ptr_d   = gnt_idx + 4'd1;

  assign bus.in_ready = take ? ({{(N_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // Select the granted channel's data slice
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        sel_data = bus.in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Output-stage FSM: load on grant, drain when the beat leaves with nothing to replace it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (gnt_any) begin
            state_q <= FULL;
            data_q  <= sel_data;
            sel_q   <= gnt_idx;
            ptr_q   <= ptr_d;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            if (gnt_any) begin
              data_q <= sel_data;
              sel_q  <= gnt_idx;
              ptr_q  <= ptr_d;
            end else begin
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux_16to1_rr_arbiter.sv
// Directed bench for the 16-to-1 round-robin mux: table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_mux_16to1_rr_arbiter;

  logic clk;
  logic rst_n;
  int   assertCount = 0;
  int   failCount   = 0;

  mux_16to1_rr_arbiter_if bus ();

  mux_16to1_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] iv;
    logic [15:0] id;
    logic        ordy;
    logic [15:0] expIr;
    logic        expOv;
    logic [3:0]  expSel;
    logic        expD;
  } vec_t;

  vec_t vecs [10];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [15:0] iv, input logic [15:0] id, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive, check in_ready before the edge, check registered outputs after it
  task automatic runVector(input string tag, input logic [15:0] iv, input logic [15:0] id,
                           input logic ordy, input logic [15:0] expIr, input logic expOv,
                           input logic [3:0] expSel, input logic expD);
    applyStimulus(iv, id, ordy);
    #1;
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'(expIr));
    @(posedge clk);
    #1;
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'(expOv));
    checkOutput({tag, " out_sel"}, 32'(bus.out_sel), 32'(expSel));
    checkOutput({tag, " out_data"}, 32'(bus.out_data), 32'(expD));
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks the immediate clear, releases at the negedge
  task automatic resetPulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " rst out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " rst out_sel"}, 32'(bus.out_sel), 32'd0);
    checkOutput({tag, " rst out_data"}, 32'(bus.out_data), 32'd0);
    checkOutput({tag, " rst in_ready"}, 32'(bus.in_ready), 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] fairData;
    fairData = 16'hA5C3;

    // Vectors start from reset: EMPTY, rr_ptr = 0
    vecs[0] = '{16'h0020, 16'h0020, 1'b1, 16'h0020, 1'b1, 4'd5,  1'b1};
    vecs[1] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd5,  1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd5,  1'b1};
    vecs[3] = '{16'h0041, 16'h0040, 1'b1, 16'h0040, 1'b1, 4'd6,  1'b1};
    vecs[4] = '{16'h0041, 16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0,  1'b1};
    vecs[5] = '{16'h0003, 16'h0002, 1'b0, 16'h0000, 1'b1, 4'd0,  1'b1};
    vecs[6] = '{16'h0003, 16'h0002, 1'b1, 16'h0002, 1'b1, 4'd1,  1'b1};
    vecs[7] = '{16'h0001, 16'h0000, 1'b1, 16'h0001, 1'b1, 4'd0,  1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b1, 16'h8000, 1'b1, 4'd15, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd15, 1'b1};

    rst_n = 1'b1;
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("init out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("init out_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("init out_data", 32'(bus.out_data), 32'd0);
    checkOutput("init in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].iv, vecs[i].id, vecs[i].ordy,
                vecs[i].expIr, vecs[i].expOv, vecs[i].expSel, vecs[i].expD);
    end

    // All 16 requesting after reset: grants 0..15 then wrap to 0
    resetPulse("fair");
    for (int i = 0; i < 17; i++) begin
      runVector($sformatf("fair%0d", i), 16'hFFFF, fairData, 1'b1,
                16'(1) << (i % 16), 1'b1, 4'(i % 16), fairData[i % 16]);
    end

    // Wrap: reach rr_ptr = 15 via a grant on 14, then 15 wins before 0, leaving rr_ptr = 1
    runVector("wrapSetup", 16'h4000, 16'h0000, 1'b1, 16'h4000, 1'b1, 4'd14, 1'b0);
    runVector("wrap15", 16'h8001, 16'h8000, 1'b1, 16'h8000, 1'b1, 4'd15, 1'b1);
    runVector("wrap0", 16'h0001, 16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1);
    runVector("wrapPtr", 16'h0003, 16'h0000, 1'b1, 16'h0002, 1'b1, 4'd1, 1'b0);

    // Backpressure: hold channel 3's beat for 4 cycles, then channel 4 loads as it leaves
    runVector("bpLoad", 16'h0008, 16'h0008, 1'b1, 16'h0008, 1'b1, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      runVector($sformatf("bpHold%0d", i), 16'h0030, 16'h0010, 1'b0, 16'h0000, 1'b1, 4'd3, 1'b1);
    end
    runVector("bpRelease", 16'h0030, 16'h0010, 1'b1, 16'h0010, 1'b1, 4'd4, 1'b1);

    // Reset while FULL clears outputs at once and returns rr_ptr to 0
    resetPulse("mid");
    runVector("midRestart", 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 4'd0, 1'b1);
    runVector("midDrain", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0, 1'b1);
    runVector("midPtr", 16'h0003, 16'h0000, 1'b1, 16'h0002, 1'b1, 4'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
